// File: rtl/matrix_pkg.sv
// Shared constants, state type and packed-bus helpers for the matrix datapath.
package matrix_pkg;
    localparam int ELEM_W  = 16;
    localparam int MAX_DIM = 5;
    localparam int DIM_W   = 3;
    localparam int OFF_W   = 9;
    localparam int BUS_W   = MAX_DIM * MAX_DIM * ELEM_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } stream_state_t;

    // Bit offset of element (row,col) in the packed bus; stride is MAX_DIM per row.
    function automatic logic [OFF_W-1:0] elem_offset(input logic [DIM_W-1:0] row,
                                                     input logic [DIM_W-1:0] col);
        logic [OFF_W-1:0] idx;
        idx = OFF_W'(row) * OFF_W'(MAX_DIM) + OFF_W'(col);
        return idx * OFF_W'(ELEM_W);
    endfunction

    function automatic logic dim_ok(input logic [DIM_W-1:0] d);
        return (d != '0) && (d <= DIM_W'(MAX_DIM));
    endfunction
endpackage

// File: rtl/matrix_rc_counter.sv
// Row-major row/col walker over an m x n matrix; holds at the last element.
module matrix_rc_counter
    import matrix_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             advance,
    input  logic [DIM_W-1:0] m,
    input  logic [DIM_W-1:0] n,
    output logic [DIM_W-1:0] row,
    output logic [DIM_W-1:0] col,
    output logic             last
);
    logic col_end;
    logic row_end;

    assign col_end = (col == n - DIM_W'(1));
    assign row_end = (row == m - DIM_W'(1));
    assign last    = col_end && row_end;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row <= '0;
            col <= '0;
        end else if (load) begin
            row <= '0;
            col <= '0;
        end else if (advance && !last) begin
            if (col_end) begin
                col <= '0;
                row <= row + DIM_W'(1);
            end else begin
                col <= col + DIM_W'(1);
            end
        end
    end
endmodule

// File: rtl/matrix_result_streamer.sv
// Captures one packed product matrix and streams it element by element, row-major.
// Optional dimension header beat: define MATRIX_STREAM_HEADER_EN.
module matrix_result_streamer
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic              in_mulError,
    input  logic [DIM_W-1:0]  c_m,
    input  logic [DIM_W-1:0]  c_n,
    input  logic [BUS_W-1:0]  aMulB,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ELEM_W-1:0] out_data,
    output logic [DIM_W-1:0]  out_row,
    output logic [DIM_W-1:0]  out_col,
    output logic              out_last,
    output logic              out_is_header,
    output logic              busy,
    output logic              done,
    output logic              error,
    output stream_state_t     state_dbg
);
    // Handshake: a beat transfers on a rising edge where out_valid && out_ready;
    // out_valid never drops and the beat never changes until that edge.
    stream_state_t    state_q, state_d;
    logic [BUS_W-1:0] cap_bus;
    logic [DIM_W-1:0] cap_m, cap_n;
    logic [DIM_W-1:0] row, col;
    logic             last;
    logic             accept, load, reject, advance, error_q;

    assign accept  = in_valid && !in_mulError && dim_ok(c_m) && dim_ok(c_n);
    assign load    = (state_q == ST_IDLE) && start && accept;
    assign reject  = (state_q == ST_IDLE) && start && !accept;
    assign advance = (state_q == ST_STREAM) && out_ready;

    matrix_rc_counter u_rc (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .advance (advance),
        .m       (cap_m),
        .n       (cap_n),
        .row     (row),
        .col     (col),
        .last    (last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cap_bus <= '0;
            cap_m   <= '0;
            cap_n   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            error_q <= reject;
            if (load) begin
                cap_bus <= aMulB;
                cap_m   <= c_m;
                cap_n   <= c_n;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        out_valid     = 1'b0;
        out_data      = '0;
        out_row       = '0;
        out_col       = '0;
        out_last      = 1'b0;
        out_is_header = 1'b0;
        case (state_q)
            ST_IDLE: begin
`ifdef MATRIX_STREAM_HEADER_EN
                if (load) state_d = ST_HEADER;
`else
                if (load) state_d = ST_STREAM;
`endif
            end
`ifdef MATRIX_STREAM_HEADER_EN
            ST_HEADER: begin
                out_valid     = 1'b1;
                out_is_header = 1'b1;
                out_data      = {{(ELEM_W - 2*DIM_W){1'b0}}, cap_m, cap_n};
                if (out_ready) state_d = ST_STREAM;
            end
`endif
            ST_STREAM: begin
                out_valid = 1'b1;
                out_data  = cap_bus[elem_offset(row, col) +: ELEM_W];
                out_row   = row;
                out_col   = col;
                out_last  = last;
                if (out_ready && last) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign error     = error_q;
    assign state_dbg = state_q;
endmodule
